// File: rtl/fb_pkg.sv
// fb_pkg: shared geometry, checkerboard pattern rule and sweep states for the frame buffer
package fb_pkg;
    localparam int FB_ADDR_W = 15;
    localparam int FB_X_W    = 8;
    localparam int FB_DEPTH  = 1 << FB_ADDR_W;
    localparam int FB_WIDTH  = 1 << FB_X_W;
    localparam int FB_HEIGHT = FB_DEPTH / FB_WIDTH;

    typedef enum logic {IDLE, BUSY} fb_state_t;

    function automatic logic fb_pattern(input int unsigned addr, input int x_w = FB_X_W);
        return addr[0] ^ addr[x_w];
    endfunction
endpackage

// File: rtl/fb_ram_tdp.sv
// fb_ram_tdp: 1-bit RAM, write-first read/write port A plus read-first read-only port B
module fb_ram_tdp
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int X_W    = FB_X_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              we_a,
    input  logic              data_a,
    output logic              q_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              q_b
);
    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [DEPTH-1:0] init_image();
        for (int i = 0; i < DEPTH; i++) init_image[i] = fb_pattern(i, X_W);
    endfunction

    logic [DEPTH-1:0] mem = init_image();

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        q_a <= clr ? 1'b0 : (we_a ? data_a : mem[addr_a]);
        q_b <= clr ? 1'b0 : mem[addr_b];
    end
endmodule

// File: rtl/frame_buffer.sv
// frame_buffer: 256x128 monochrome frame store with reset-time checkerboard repaint sweep
module frame_buffer
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int X_W    = FB_X_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic              data_in_A,
    input  logic              we_A,
    output logic              data_out_A,
    input  logic [ADDR_W-1:0] addr_B,
    output logic              data_out_B,
    output logic              init_busy
);
    fb_state_t         state = IDLE;
    fb_state_t         state_n;
    logic [ADDR_W-1:0] cnt;
    logic              busy;
    logic              last;

    always_comb begin
        busy    = state == BUSY;
        last    = &cnt;
        state_n = busy && last ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        state <= reset ? BUSY : state_n;
        cnt   <= reset ? '0 : cnt + ADDR_W'(busy);
    end

    assign init_busy = busy;

    // The sweep owns the write port while busy; outputs stay cleared until it finishes
    fb_ram_tdp #(.ADDR_W(ADDR_W), .X_W(X_W)) u_ram (
        .clk    (clk),
        .clr    (reset | busy),
        .addr_a (busy ? cnt : addr_A),
        .we_a   (busy | we_A),
        .data_a (busy ? fb_pattern(32'(cnt), X_W) : data_in_A),
        .q_a    (data_out_A),
        .addr_b (addr_B),
        .q_b    (data_out_B)
    );
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: randomized check of frame_buffer against an array model of the frame
module tb_frame_buffer;
    localparam int DEPTH = 32768;
    localparam int SWEEP = 32768;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] addr_A = '0;
    logic [14:0] addr_B = '0;
    logic        data_in_A = 1'b0;
    logic        we_A = 1'b0;
    logic        data_out_A;
    logic        data_out_B;
    logic        init_busy;

    int checks = 0;
    int failures = 0;
    bit model [DEPTH];

    frame_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .addr_A     (addr_A),
        .data_in_A  (data_in_A),
        .we_A       (we_A),
        .data_out_A (data_out_A),
        .addr_B     (addr_B),
        .data_out_B (data_out_B),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    function automatic bit checker_pixel(int a);
        int x = a % 256;
        int y = a / 256;
        return bit'((x % 2) ^ (y % 2));
    endfunction

    task automatic repaint();
        for (int i = 0; i < DEPTH; i++) model[i] = checker_pixel(i);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] pick();
        return $urandom_range(0, 3) == 0 ? 15'($urandom_range(0, 7)) : 15'($urandom);
    endfunction

    task automatic step(input logic [14:0] a, input logic di, input logic we, input logic [14:0] b);
        bit ea, eb;
        @(negedge clk);
        addr_A = a; data_in_A = di; we_A = we; addr_B = b;
        @(posedge clk);
        ea = we ? di : model[a];
        eb = model[b];
        if (we) model[a] = di;
        #1;
        check("port_a", data_out_A, ea);
        check("port_b", data_out_B, eb);
        check("idle_busy", init_busy, 0);
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) step(pick(), 1'($urandom), 1'($urandom), pick());
    endtask

    // abort_at > 0 re-asserts reset that many cycles into the sweep
    task automatic sweep(input int abort_at);
        int k = 1;
        @(negedge clk);
        reset = 1'b1; we_A = 1'b1; data_in_A = 1'($urandom); addr_A = 15'($urandom); addr_B = 15'($urandom);
        @(posedge clk);
        #1;
        check("reset_edge", {data_out_A, data_out_B, init_busy}, 3'b001);
        while (k <= SWEEP) begin
            @(negedge clk);
            reset = (k == abort_at);
            we_A = 1'b1; data_in_A = 1'($urandom); addr_A = 15'($urandom); addr_B = 15'($urandom);
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                check("rereset_edge", {data_out_A, data_out_B, init_busy}, 3'b001);
                abort_at = -1;
                k = 1;
            end else begin
                check(k == SWEEP ? "sweep_done" : "sweep", {data_out_A, data_out_B, init_busy},
                      k == SWEEP ? 3'b000 : 3'b001);
                k++;
            end
        end
        reset = 1'b0;
        we_A = 1'b0;
        repaint();
    endtask

    initial begin
        repaint();
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(256, 0, 0, 0);
        step(257, 0, 0, 1);
        check("pixel_257", data_out_A, 0);
        step(15, 1, 1, 15);
        step(15, 0, 0, 15);
        step(15, 0, 1, 15);
        step(15, 0, 0, 15);
        step(5000, 1, 1, 0);
        step(5000, 0, 0, 5000);
        step(0, 1, 1, 0);
        check("collision_old", data_out_B, 0);
        step(7, 0, 0, 0);
        check("collision_new", data_out_B, 1);
        random_ops(1500);
        sweep(-1);
        step(15, 0, 0, 5000);
        step(5000, 0, 0, 32767);
        step(32767, 0, 0, 15);
        random_ops(200);
        sweep(1000);
        random_ops(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
